port_slew_multi: RTL

//  Multi-channel successor to the single-channel PORT block. Holds CHANNELS

---
 rtl/port_slew_multi.sv | 97 +++++++++
 1 files changed

// File: rtl/port_slew_multi.sv
// Multi-channel slewing output ports. Host writes per-channel target/step over an
// asynchronous strobe bus; each output walks toward its target by step on every tick.
module port_slew_multi #(
  parameter int DATA_W       = 16,
  parameter int CHANNELS     = 4,
  parameter int TICK_DIV     = 1,
  parameter int SYNC_STAGES  = 2,
  parameter int DEFAULT_STEP = 4
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            WE,
  input  logic                                            WCLK,
  input  logic                                            WSEL,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] WADDR,
  input  logic [DATA_W-1:0]                               WDATA,
  output logic [CHANNELS*DATA_W-1:0]                      GEN_OUT,
  output logic [CHANNELS-1:0]                             AT_TARGET,
  output logic                                            WACK
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   edge_reg;
  logic                   wack_reg;
  logic [TC_W-1:0]        tick_cnt_reg;
  logic                   tick;
  logic                   addr_ok;
  logic                   wr_en;

  assign tick    = (tick_cnt_reg == TC_W'(TICK_DIV - 1));
  assign addr_ok = (32'(WADDR) < 32'(CHANNELS));
  assign wr_en   = edge_reg & WE & addr_ok;
  assign WACK    = wack_reg;

  // Chain and prev load 1 so a strobe already high through reset is not seen as a rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg     <= '1;
      prev_reg     <= 1'b1;
      edge_reg     <= 1'b0;
      wack_reg     <= 1'b0;
      tick_cnt_reg <= '0;
    end else begin
      sync_reg     <= {sync_reg[SYNC_STAGES-2:0], WCLK};
      prev_reg     <= sync_reg[SYNC_STAGES-1];
      edge_reg     <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
      wack_reg     <= wr_en;
      tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 1'b1;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [DATA_W-1:0] tgt_reg;
    logic [DATA_W-1:0] step_reg;
    logic [DATA_W-1:0] out_reg;
    logic              at_reg;
    logic [DATA_W-1:0] out_next;
    logic [DATA_W-1:0] tgt_next;
    logic [DATA_W-1:0] diff;
    logic              sel_ch;

    assign sel_ch   = wr_en && (WADDR == CH_W'(gi));
    assign tgt_next = (sel_ch && !WSEL) ? WDATA : tgt_reg;

    // Distance is always larger-minus-smaller, so the step never overshoots or wraps.
    always_comb begin
      diff     = (out_reg < tgt_reg) ? (tgt_reg - out_reg) : (out_reg - tgt_reg);
      out_next = out_reg;
      if (tick && (out_reg != tgt_reg)) begin
        if ((step_reg == '0) || (diff <= step_reg)) out_next = tgt_reg;
        else if (out_reg < tgt_reg)                 out_next = out_reg + step_reg;
        else                                        out_next = out_reg - step_reg;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        tgt_reg  <= '0;
        step_reg <= DATA_W'(DEFAULT_STEP);
        out_reg  <= '0;
        at_reg   <= 1'b1;
      end else begin
        out_reg <= out_next;
        tgt_reg <= tgt_next;
        at_reg  <= (out_next == tgt_next);
        if (sel_ch && WSEL) step_reg <= WDATA;
      end
    end

    assign GEN_OUT[gi*DATA_W +: DATA_W] = out_reg;
    assign AT_TARGET[gi]                = at_reg;
  end

endmodule
